// File: rtl/int_to_fp32_if.sv
// Handshake bundle for the integer-to-fp32 converter: operand in, packed float out.
interface int_to_fp32_if;
  logic        i_valid;
  logic        o_ready;
  logic        i_signed;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_c;
  logic        o_inexact;

  modport master (output i_valid, i_signed, i_data, i_ready,
                  input  o_ready, o_valid, o_c, o_inexact);
  modport slave  (input  i_valid, i_signed, i_data, i_ready,
                  output o_ready, o_valid, o_c, o_inexact);
endinterface

// File: rtl/int_to_fp32.sv
// Iterative 32-bit integer to IEEE-754 single converter; normalises one bit per cycle.
module int_to_fp32 #(
  parameter int ROUND_MODE = 0  // 0: round-to-nearest-even, 1: round-toward-zero
) (
  input  logic          i_clk,
  input  logic          i_reset,
  int_to_fp32_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic [31:0] data;
  logic        sign;
  logic [31:0] mag;
  logic [7:0]  exp;
  logic        zero;

  logic        guard, sticky, round_up;
  logic [23:0] mant_inc;
  logic [22:0] mant_rnd;
  logic [7:0]  exp_rnd;

  // mag[31] is the hidden bit once normalised; a carry out of the
  // incremented mantissa bumps the exponent and leaves the fraction at zero.
  always_comb begin
    guard    = mag[7];
    sticky   = |mag[6:0];
    round_up = (ROUND_MODE == 0) && guard && (sticky || mag[8]);
    mant_inc = {1'b0, mag[30:8]} + 24'd1;
    mant_rnd = round_up ? mant_inc[22:0] : mag[30:8];
    exp_rnd  = exp + {7'd0, round_up & mant_inc[23]};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      data          <= '0;
      sign          <= 1'b0;
      mag           <= '0;
      exp           <= '0;
      zero          <= 1'b0;
      bus.o_ready   <= 1'b1;
      bus.o_valid   <= 1'b0;
      bus.o_c       <= '0;
      bus.o_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_valid && bus.o_ready) begin
          data        <= bus.i_data;
          sign        <= bus.i_signed & bus.i_data[31];
          bus.o_ready <= 1'b0;
          state       <= ABS;
        end
        ABS: begin
          // -2^31 negates to itself, which is the correct magnitude
          mag   <= sign ? (~data + 32'd1) : data;
          exp   <= 8'd158;
          zero  <= (data == 32'd0);
          state <= (data == 32'd0) ? ROUND : NORM;
        end
        NORM: begin
          if (mag[31]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end
        end
        ROUND: begin
          if (zero) begin
            bus.o_c       <= '0;
            bus.o_inexact <= 1'b0;
          end else begin
            bus.o_c       <= {sign, exp_rnd, mant_rnd};
            bus.o_inexact <= guard | sticky;
          end
          bus.o_valid <= 1'b1;
          state       <= DONE;
        end
        DONE: if (bus.i_ready) begin
          bus.o_valid <= 1'b0;
          bus.o_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp32.sv
// Bench for int_to_fp32: RNE and RTZ instances driven in lockstep, table + random vs. model.
module tb_int_to_fp32;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  int_to_fp32_if bus_rne();
  int_to_fp32_if bus_rtz();

  int_to_fp32 #(.ROUND_MODE(0)) dut_rne (.i_clk(i_clk), .i_reset(i_reset), .bus(bus_rne.slave));
  int_to_fp32 #(.ROUND_MODE(1)) dut_rtz (.i_clk(i_clk), .i_reset(i_reset), .bus(bus_rtz.slave));

  int total = 0;
  int passed = 0;

  typedef struct {
    bit        sg;
    bit [31:0] d;
    bit [31:0] c_rne;
    bit [31:0] c_rtz;
    bit        inx;
    int        lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  // Reference: exact real-number rounding on the integer magnitude.
  function automatic void model(input bit sg, input bit [31:0] d, input bit rtz,
                                output bit [31:0] c, output bit inx, output int lat);
    bit [63:0] m, q, rem, half;
    bit        neg;
    int        p, e, drop;
    neg = sg && d[31];
    m   = neg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    c = 0; inx = 0; lat = 2; p = 0;
    if (m == 0) return;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    lat = (31 - p) + 3;
    e   = 127 + p;
    rem = 0;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      drop = p - 23;
      q    = m >> drop;
      rem  = m & ((64'd1 << drop) - 64'd1);
      half = 64'd1 << (drop - 1);
      if (!rtz && (rem > half || (rem == half && q[0]))) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    c   = {neg, e[7:0], q[22:0]};
    inx = (rem != 0);
  endfunction

  task automatic drive_in(input bit v, input bit sg, input bit [31:0] d);
    bus_rne.i_valid = v; bus_rne.i_signed = sg; bus_rne.i_data = d;
    bus_rtz.i_valid = v; bus_rtz.i_signed = sg; bus_rtz.i_data = d;
  endtask

  task automatic drive_rdy(input bit r);
    bus_rne.i_ready = r;
    bus_rtz.i_ready = r;
  endtask

  // Caller is #1 after a posedge with both converters idle.
  task automatic convert(input string tag, input bit sg, input bit [31:0] d, input bit early,
                         input bit [31:0] w_rne, input bit [31:0] w_rtz,
                         input bit w_inx_rne, input bit w_inx_rtz, input int w_lat);
    int lat;
    drive_rdy(early);
    drive_in(1'b1, sg, d);
    @(posedge i_clk); #1;
    drive_in(1'b0, ~sg, ~d);
    lat = 0;
    while (!bus_rne.o_valid && lat < 60) begin
      @(posedge i_clk); #1;
      lat++;
    end
    if (lat >= 60) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, " latency"}, lat, w_lat);
    check({tag, " rtz valid"}, bus_rtz.o_valid, 1'b1);
    check({tag, " rne c"}, bus_rne.o_c, w_rne);
    check({tag, " rtz c"}, bus_rtz.o_c, w_rtz);
    check({tag, " rne inexact"}, bus_rne.o_inexact, w_inx_rne);
    check({tag, " rtz inexact"}, bus_rtz.o_inexact, w_inx_rtz);
    drive_rdy(1'b1);
    @(posedge i_clk); #1;
    drive_rdy(1'b0);
    check({tag, " valid drop"}, {bus_rne.o_valid, bus_rtz.o_valid}, 2'b00);
    check({tag, " ready rise"}, {bus_rne.o_ready, bus_rtz.o_ready}, 2'b11);
    check({tag, " c held"}, bus_rne.o_c, w_rne);
  endtask

  initial begin
    bit [31:0] c0, c1, hold_c, d;
    bit        x0, x1, sg;
    int        l0, l1;

    tbl.push_back('{0, 32'h00000001, 32'h3F800000, 32'h3F800000, 0, 34});
    tbl.push_back('{1, 32'hFFFFFFFF, 32'hBF800000, 32'hBF800000, 0, 34});
    tbl.push_back('{1, 32'h80000000, 32'hCF000000, 32'hCF000000, 0, 3});
    tbl.push_back('{0, 32'h80000000, 32'h4F000000, 32'h4F000000, 0, 3});
    tbl.push_back('{0, 32'hFFFFFFFF, 32'h4F800000, 32'h4F7FFFFF, 1, 3});
    tbl.push_back('{0, 32'h01000001, 32'h4B800000, 32'h4B800000, 1, 10});
    tbl.push_back('{0, 32'h01000003, 32'h4B800002, 32'h4B800001, 1, 10});
    tbl.push_back('{0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 2});
    tbl.push_back('{1, 32'h00000000, 32'h00000000, 32'h00000000, 0, 2});
    tbl.push_back('{0, 32'h00000064, 32'h42C80000, 32'h42C80000, 0, 28});
    tbl.push_back('{0, 32'hFFFFFFFF, 32'h4F800000, 32'h4F7FFFFF, 1, 3});

    drive_in(1'b0, 1'b0, 32'd0);
    drive_rdy(1'b0);
    #12;
    check("reset ready", bus_rne.o_ready, 1'b1);
    check("reset valid", bus_rne.o_valid, 1'b0);
    check("reset c", bus_rne.o_c, 32'd0);
    check("reset inexact", bus_rne.o_inexact, 1'b0);
    i_reset = 1'b1;
    @(posedge i_clk); #1;

    foreach (tbl[i])
      convert($sformatf("vec%0d", i), tbl[i].sg, tbl[i].d, 1'b0,
              tbl[i].c_rne, tbl[i].c_rtz, tbl[i].inx, tbl[i].inx, tbl[i].lat);

    // i_ready asserted before the result exists must not cut it short
    convert("early_ready", 1'b1, 32'hFFFFFF9C, 1'b1, 32'hC2C80000, 32'hC2C80000, 0, 0, 28);

    for (int n = 0; n < 200; n++) begin
      d  = $urandom >> $urandom_range(0, 31);
      sg = $urandom_range(0, 1);
      model(sg, d, 1'b0, c0, x0, l0);
      model(sg, d, 1'b1, c1, x1, l1);
      convert($sformatf("rnd%0d %h", n, d), sg, d, n[0], c0, c1, x0, x1, l0);
    end

    // backpressure: result and handshake state frozen while i_ready is low
    drive_in(1'b1, 1'b0, 32'h12345678);
    @(posedge i_clk); #1;
    drive_in(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 60 && !bus_rne.o_valid; k++) begin
      @(posedge i_clk); #1;
    end
    model(1'b0, 32'h12345678, 1'b0, c0, x0, l0);
    check("bp first c", bus_rne.o_c, c0);
    hold_c = bus_rne.o_c;
    drive_in(1'b1, 1'b1, 32'hFFFFFFFF);
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      check("bp valid held", bus_rne.o_valid, 1'b1);
      check("bp c held", bus_rne.o_c, hold_c);
      check("bp ready low", bus_rne.o_ready, 1'b0);
    end
    drive_in(1'b0, 1'b0, 32'h0);
    drive_rdy(1'b1);
    @(posedge i_clk); #1;
    drive_rdy(1'b0);
    check("bp valid drop", bus_rne.o_valid, 1'b0);
    check("bp ready rise", bus_rne.o_ready, 1'b1);
    @(posedge i_clk); #1;
    check("bp no late accept", {bus_rne.o_ready, bus_rne.o_valid}, 2'b10);
    check("bp c retained", bus_rne.o_c, hold_c);

    // asynchronous reset in the middle of normalisation
    drive_in(1'b1, 1'b0, 32'h00000001);
    @(posedge i_clk); #1;
    drive_in(1'b0, 1'b0, 32'h0);
    repeat (5) @(posedge i_clk);
    #3;
    i_reset = 1'b0;
    #1;
    check("async rst ready", bus_rne.o_ready, 1'b1);
    check("async rst valid", bus_rne.o_valid, 1'b0);
    check("async rst c", bus_rne.o_c, 32'd0);
    check("async rst rtz c", bus_rtz.o_c, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    repeat (40) @(posedge i_clk);
    #1;
    check("aborted no output", bus_rne.o_valid, 1'b0);
    convert("after reset", 1'b0, 32'h00000064, 1'b0, 32'h42C80000, 32'h42C80000, 0, 0, 28);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
